// File: rtl/viterbi_acs4.sv
// Add-compare-select and path-metric stage for a rate-1/2, K=3 (g0=111, g1=101) Viterbi decoder.
// Four trellis states, registered survivor decisions, best state and metric normalisation.
module viterbi_acs4 #(
  parameter int unsigned PM_W     = 8,
  parameter int unsigned INIT_PEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [1:0]      bm00,
  input  logic [1:0]      bm01,
  input  logic [1:0]      bm10,
  input  logic [1:0]      bm11,
  output logic            out_valid,
  output logic [3:0]      decision,
  output logic [1:0]      best_state,
  output logic [PM_W-1:0] best_pm,
  output logic            norm_event
);

  localparam int unsigned CW = PM_W + 1;
  localparam logic [PM_W-1:0] PEN = PM_W'(INIT_PEN);

  logic [PM_W-1:0] pm     [4];
  logic [PM_W-1:0] old_pm [4];
  logic [CW-1:0]   cand0  [4];
  logic [CW-1:0]   cand1  [4];
  logic [CW-1:0]   sel    [4];
  logic [PM_W-1:0] sat_pm [4];
  logic [PM_W-1:0] new_pm [4];
  logic [3:0]      dec_c;
  logic            all_msb_c;
  logic [1:0]      best_idx_c;
  logic [PM_W-1:0] best_val_c;

  // First symbol of a frame uses the initial metrics as the old path metrics
  always_comb begin
    old_pm[0] = pm[0];
    old_pm[1] = pm[1];
    old_pm[2] = pm[2];
    old_pm[3] = pm[3];
    if (start) begin
      old_pm[0] = '0;
      old_pm[1] = PEN;
      old_pm[2] = PEN;
      old_pm[3] = PEN;
    end
  end

  // Next state n=2u+a: even predecessor 2a, odd 2a+1; symbol c0=u^a^s0, c1=u^s0
  always_comb begin
    cand0[0] = CW'(old_pm[0]) + CW'(bm00);
    cand1[0] = CW'(old_pm[1]) + CW'(bm11);
    cand0[1] = CW'(old_pm[2]) + CW'(bm10);
    cand1[1] = CW'(old_pm[3]) + CW'(bm01);
    cand0[2] = CW'(old_pm[0]) + CW'(bm11);
    cand1[2] = CW'(old_pm[1]) + CW'(bm00);
    cand0[3] = CW'(old_pm[2]) + CW'(bm01);
    cand1[3] = CW'(old_pm[3]) + CW'(bm10);
  end

  // Compare-select with ties to the even predecessor, then saturate
  always_comb begin
    dec_c = '0;
    for (int i = 0; i < 4; i++) begin
      sel[i] = cand0[i];
      if (cand1[i] < cand0[i]) begin
        sel[i]   = cand1[i];
        dec_c[i] = 1'b1;
      end
      sat_pm[i] = sel[i][PM_W] ? '1 : sel[i][PM_W-1:0];
    end
  end

  // Normalise when every metric has crossed the half-range point
  always_comb begin
    all_msb_c = sat_pm[0][PM_W-1] & sat_pm[1][PM_W-1] & sat_pm[2][PM_W-1] & sat_pm[3][PM_W-1];
    for (int i = 0; i < 4; i++) begin
      new_pm[i] = sat_pm[i];
      if (all_msb_c) new_pm[i][PM_W-1] = 1'b0;
    end
  end

  // Minimum search; strict compare keeps the lowest index on ties
  always_comb begin
    best_idx_c = '0;
    best_val_c = new_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (new_pm[i] < best_val_c) begin
        best_val_c = new_pm[i];
        best_idx_c = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm[0]      <= '0;
      pm[1]      <= PEN;
      pm[2]      <= PEN;
      pm[3]      <= PEN;
      out_valid  <= 1'b0;
      decision   <= '0;
      best_state <= '0;
      best_pm    <= '0;
      norm_event <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      norm_event <= in_valid & all_msb_c;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) pm[i] <= new_pm[i];
        decision   <= dec_c;
        best_state <= best_idx_c;
        best_pm    <= best_val_c;
      end else if (start) begin
        pm[0] <= '0;
        pm[1] <= PEN;
        pm[2] <= PEN;
        pm[3] <= PEN;
      end
    end
  end

endmodule
